// File: rtl/com2fifoc_pkg.sv
// com2fifoc_pkg: command-frame constants and receiver state encoding,
// shared between the frame receiver and the command-parse stage.
package com2fifoc_pkg;

  localparam logic [7:0] HDR0      = 8'h55;
  localparam logic [7:0] HDR1      = 8'hAA;
  localparam int         FRAME_LEN = 12;
  localparam int         BODY_LEN  = 10;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HED1,
    ST_BODY,
    ST_CHK,
    ST_WRITE,
    ST_SYNC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/com2fifoc.sv
// com2fifoc: hunts the link byte stream for a 0x55 0xAA header, buffers one
// 12-byte command frame, verifies its checksum, copies good frames into the
// command FIFO and then handshakes with the parse stage via fs/fd.
module com2fifoc
  import com2fifoc_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  output logic       fifoc_txen,
  output logic [7:0] fifoc_txd,
  input  logic       fifoc_full,
  output logic       fs,
  input  logic       fd,
  output logic       err,
  output logic [7:0] frm_cnt
);

  state_t      r_state;
  logic [7:0]  r_buf [FRAME_LEN];
  logic [7:0]  r_sum;
  logic [3:0]  r_idx;
  logic [3:0]  r_ptr;
  logic [15:0] r_gap;
  logic        r_txen;
  logic [7:0]  r_txd;
  logic        r_fs;
  logic        r_err;
  logic [7:0]  r_frmCnt;

  logic        w_discard;
  logic        w_timeout;
  logic        w_chkOk;
  logic [15:0] w_gapInc;

  // A byte arriving while the receiver is busy verifying, writing or
  // handshaking cannot be used and is reported as a dropped byte.
  assign w_discard = rx_vld && ((r_state == ST_CHK)  || (r_state == ST_WRITE) ||
                                (r_state == ST_SYNC) || (r_state == ST_DONE));

  // A partially received frame is abandoned once the line has been idle for
  // TIMEOUT cycles; a byte arriving on that same cycle still wins.
  assign w_timeout = ((r_state == ST_HED1) || (r_state == ST_BODY)) &&
                     !rx_vld && (r_gap == TIMEOUT);

  assign w_chkOk  = (r_buf[FRAME_LEN-1] == r_sum);
  assign w_gapInc = (r_gap == 16'hFFFF) ? r_gap : r_gap + 16'd1;

  assign fifoc_txen = r_txen;
  assign fifoc_txd  = r_txd;
  assign fs         = r_fs;
  assign err        = r_err;
  assign frm_cnt    = r_frmCnt;

  // Receiver state machine: header hunt, body capture, checksum, FIFO burst
  // and the fs/fd handshake, with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_HUNT;
      for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= 8'h00;
      r_sum    <= 8'h00;
      r_idx    <= 4'd0;
      r_ptr    <= 4'd0;
      r_gap    <= 16'd0;
      r_txen   <= 1'b0;
      r_txd    <= 8'h00;
      r_fs     <= 1'b0;
      r_err    <= 1'b0;
      r_frmCnt <= 8'h00;
    end else begin
      r_err <= w_discard || w_timeout;
      r_gap <= 16'd0;
      case (r_state)
        ST_HUNT: begin
          if (rx_vld && (rx_data == HDR0)) r_state <= ST_HED1;
        end
        ST_HED1: begin
          if (rx_vld) begin
            if (rx_data == HDR1) begin
              r_state  <= ST_BODY;
              r_idx    <= 4'd0;
              r_sum    <= 8'h00;
              r_buf[0] <= HDR0;
              r_buf[1] <= HDR1;
            end else if (rx_data != HDR0) begin
              r_state <= ST_HUNT;
            end
          end else if (w_timeout) begin
            r_state <= ST_HUNT;
          end else begin
            r_gap <= w_gapInc;
          end
        end
        ST_BODY: begin
          if (rx_vld) begin
            r_buf[r_idx + 4'd2] <= rx_data;
            if (r_idx == 4'(BODY_LEN - 1)) begin
              r_state <= ST_CHK;
            end else begin
              r_sum <= r_sum + rx_data;
              r_idx <= r_idx + 4'd1;
            end
          end else if (w_timeout) begin
            r_state <= ST_HUNT;
          end else begin
            r_gap <= w_gapInc;
          end
        end
        ST_CHK: begin
          if (w_chkOk) begin
            r_state <= ST_WRITE;
            r_ptr   <= 4'd0;
          end else begin
            r_state <= ST_HUNT;
            r_err   <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!fifoc_full) begin
            r_txen <= 1'b1;
            r_txd  <= r_buf[r_ptr];
            if (r_ptr == 4'(FRAME_LEN - 1)) r_state <= ST_SYNC;
            else                            r_ptr   <= r_ptr + 4'd1;
          end else begin
            r_txen <= 1'b0;
          end
        end
        ST_SYNC: begin
          r_txen <= 1'b0;
          if (!r_fs) begin
            r_fs     <= 1'b1;
            r_frmCnt <= r_frmCnt + 8'd1;
          end else if (fd) begin
            r_fs    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!fd) r_state <= ST_HUNT;
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_com2fifoc.sv
// tb_com2fifoc: frame-level checks of the command-frame receiver against a
// queue-based model of which frames should reach the FIFO.
module tb_com2fifoc;

  localparam logic [15:0] TO = 16'd64;

  logic       clk;
  logic       rst;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       fifoc_txen;
  logic [7:0] fifoc_txd;
  logic       fifoc_full;
  logic       fs;
  logic       fd;
  logic       err;
  logic [7:0] frm_cnt;

  int checks = 0;
  int errors = 0;
  int errSeen = 0;
  logic [7:0] qGot[$];
  logic [7:0] qExp[$];
  logic [7:0] frm [12];
  logic [7:0] expFrm = 8'h00;

  com2fifoc #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
    .fifoc_txen(fifoc_txen), .fifoc_txd(fifoc_txd), .fifoc_full(fifoc_full),
    .fs(fs), .fd(fd), .err(err), .frm_cnt(frm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: capture every FIFO write and count err-high cycles.
  always @(negedge clk) begin
    if (fifoc_txen) qGot.push_back(fifoc_txd);
    if (err) errSeen++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_data = b;
    tick();
    rx_vld  = 1'b0;
  endtask

  // Builds a frame with a random body; a bad frame gets a corrupted checksum.
  task automatic make_frame(input bit good);
    logic [7:0] s;
    s = 8'h00;
    frm[0] = 8'h55;
    frm[1] = 8'hAA;
    for (int i = 2; i < 11; i++) begin
      frm[i] = 8'($urandom_range(0, 255));
      s = s + frm[i];
    end
    frm[11] = good ? s : (s ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic send_frame(input int maxGap);
    for (int i = 0; i < 12; i++) begin
      send_byte(frm[i]);
      repeat ($urandom_range(0, maxGap)) tick();
    end
  endtask

  task automatic expect_frame();
    for (int i = 0; i < 12; i++) qExp.push_back(frm[i]);
  endtask

  task automatic wait_fs(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (fs) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake();
    fd = 1'b1;
    tick();
    fd = 1'b0;
    tick();
    tick();
  endtask

  // Counts differences between captured and expected FIFO traffic, then clears both.
  task automatic fifo_diff(output int d);
    d = 0;
    if (qGot.size() != qExp.size()) d++;
    for (int i = 0; i < qExp.size(); i++)
      if (i < qGot.size() && qGot[i] !== qExp[i]) d++;
    qGot.delete();
    qExp.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks += 5;
    if (fifoc_txen !== 1'b0) begin errors++; $display("[TB] FAIL reset_txen got %b want 0", fifoc_txen); end
    if (fifoc_txd !== 8'h00) begin errors++; $display("[TB] FAIL reset_txd got %h want 00", fifoc_txd); end
    if (fs !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got %b want 0", fs); end
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
    if (frm_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_frmcnt got %h want 00", frm_cnt); end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (fs !== 1'b0 || fifoc_txen !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset fs=%b txen=%b want 0/0", fs, fifoc_txen); end
  endtask

  task automatic test_good_frame();
    int lat, burst, d;
    logic [7:0] fixed [12];
    fixed = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h2D};
    for (int i = 0; i < 12; i++) frm[i] = fixed[i];
    expect_frame();
    send_frame(0);
    lat = 0;
    while (!fifoc_txen && lat < 10) begin lat++; tick(); end
    checks++;
    if (lat !== 2) begin errors++; $display("[TB] FAIL write_latency got %0d want 2", lat); end
    burst = 0;
    while (fifoc_txen && burst < 20) begin burst++; tick(); end
    checks += 3;
    if (burst !== 12) begin errors++; $display("[TB] FAIL burst_len got %0d want 12", burst); end
    if (fs !== 1'b1) begin errors++; $display("[TB] FAIL fs_rise got %b want 1", fs); end
    expFrm++;
    if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL frmcnt_good got %h want %h", frm_cnt, expFrm); end
    fd = 1'b1;
    tick();
    checks++;
    if (fs !== 1'b0) begin errors++; $display("[TB] FAIL fs_fall got %b want 0", fs); end
    fd = 1'b0;
    tick();
    tick();
    fifo_diff(d);
    checks++;
    if (d !== 0) begin errors++; $display("[TB] FAIL good_frame_bytes got %0d diffs want 0", d); end
  endtask

  task automatic test_bad_checksum();
    int e0, d;
    logic [7:0] fixed [12];
    fixed = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h2E};
    for (int i = 0; i < 12; i++) frm[i] = fixed[i];
    e0 = errSeen;
    send_frame(0);
    repeat (20) tick();
    fifo_diff(d);
    checks += 4;
    if (errSeen - e0 !== 1) begin errors++; $display("[TB] FAIL badchk_err got %0d cycles want 1", errSeen - e0); end
    if (d !== 0) begin errors++; $display("[TB] FAIL badchk_nowrite got %0d diffs want 0", d); end
    if (fs !== 1'b0) begin errors++; $display("[TB] FAIL badchk_fs got %b want 0", fs); end
    if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL badchk_frmcnt got %h want %h", frm_cnt, expFrm); end
  endtask

  task automatic test_preamble();
    bit ok;
    int d, e0;
    make_frame(1'b1);
    expect_frame();
    e0 = errSeen;
    send_byte(8'h00);
    send_byte(8'h55);
    send_frame(1);
    wait_fs(60, ok);
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL preamble_fs got %b want 1", ok); end
    expFrm++;
    if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL preamble_frmcnt got %h want %h", frm_cnt, expFrm); end
    handshake();
    fifo_diff(d);
    checks += 2;
    if (d !== 0) begin errors++; $display("[TB] FAIL preamble_bytes got %0d diffs want 0", d); end
    if (errSeen - e0 !== 0) begin errors++; $display("[TB] FAIL preamble_err got %0d want 0", errSeen - e0); end
  endtask

  task automatic test_full_stall();
    int wc, sc, leak, d;
    bit stalled;
    make_frame(1'b1);
    expect_frame();
    send_frame(0);
    wc = 0; sc = 0; leak = 0; stalled = 1'b0;
    for (int c = 0; c < 60 && !fs; c++) begin
      tick();
      if (fifoc_full) begin
        sc++;
        if (fifoc_txen) leak++;
        if (sc == 5) fifoc_full = 1'b0;
      end else if (fifoc_txen) begin
        wc++;
        if (wc == 3 && !stalled) begin
          fifoc_full = 1'b1;
          stalled = 1'b1;
        end
      end
    end
    fifoc_full = 1'b0;
    checks += 4;
    if (wc !== 12) begin errors++; $display("[TB] FAIL stall_writes got %0d want 12", wc); end
    if (leak !== 0) begin errors++; $display("[TB] FAIL stall_leak got %0d want 0", leak); end
    if (fs !== 1'b1) begin errors++; $display("[TB] FAIL stall_fs got %b want 1", fs); end
    expFrm++;
    if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL stall_frmcnt got %h want %h", frm_cnt, expFrm); end
    handshake();
    fifo_diff(d);
    checks++;
    if (d !== 0) begin errors++; $display("[TB] FAIL stall_order got %0d diffs want 0", d); end
  endtask

  task automatic test_timeout();
    int e0, d;
    bit ok;
    make_frame(1'b1);
    e0 = errSeen;
    for (int i = 0; i < 7; i++) send_byte(frm[i]);
    repeat (int'(TO) - 1) tick();
    checks++;
    if (errSeen - e0 !== 0) begin errors++; $display("[TB] FAIL timeout_early got %0d want 0", errSeen - e0); end
    repeat (8) tick();
    fifo_diff(d);
    checks += 2;
    if (errSeen - e0 !== 1) begin errors++; $display("[TB] FAIL timeout_err got %0d want 1", errSeen - e0); end
    if (d !== 0) begin errors++; $display("[TB] FAIL timeout_nowrite got %0d diffs want 0", d); end
    make_frame(1'b1);
    expect_frame();
    send_frame(2);
    wait_fs(60, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL timeout_recover got %b want 1", ok); end
    expFrm++;
    handshake();
    fifo_diff(d);
    checks++;
    if (d !== 0) begin errors++; $display("[TB] FAIL timeout_recover_bytes got %0d diffs want 0", d); end
  endtask

  task automatic test_byte_in_sync();
    int e0, d;
    bit ok;
    make_frame(1'b1);
    expect_frame();
    send_frame(0);
    wait_fs(60, ok);
    expFrm++;
    e0 = errSeen;
    send_byte(8'($urandom_range(0, 255)));
    tick();
    checks += 3;
    if (ok !== 1'b1 || fs !== 1'b1) begin errors++; $display("[TB] FAIL sync_fs got %b want 1", fs); end
    if (errSeen - e0 !== 1) begin errors++; $display("[TB] FAIL sync_discard_err got %0d want 1", errSeen - e0); end
    if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL sync_frmcnt got %h want %h", frm_cnt, expFrm); end
    handshake();
    fifo_diff(d);
    checks++;
    if (d !== 0) begin errors++; $display("[TB] FAIL sync_bytes got %0d diffs want 0", d); end
  endtask

  task automatic test_random();
    int e0, d, nz;
    bit good, ok;
    logic [7:0] b;
    for (int n = 0; n < 12; n++) begin
      good = ($urandom_range(0, 3) != 0);
      nz = $urandom_range(0, 3);
      repeat (nz) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'h00;
        send_byte(b);
      end
      make_frame(good);
      if (good) expect_frame();
      e0 = errSeen;
      send_frame(3);
      if (good) begin
        wait_fs(60, ok);
        expFrm++;
        checks += 2;
        if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rand_fs[%0d] got %b want 1", n, ok); end
        if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL rand_frmcnt[%0d] got %h want %h", n, frm_cnt, expFrm); end
        handshake();
      end else begin
        repeat (6) tick();
      end
      fifo_diff(d);
      checks += 2;
      if (errSeen - e0 !== (good ? 0 : 1)) begin errors++; $display("[TB] FAIL rand_err[%0d] got %0d want %0d", n, errSeen - e0, good ? 0 : 1); end
      if (d !== 0) begin errors++; $display("[TB] FAIL rand_bytes[%0d] got %0d diffs want 0", n, d); end
    end
  endtask

  task automatic test_reset_mid_write();
    int wc, d;
    bit ok;
    make_frame(1'b1);
    send_frame(0);
    wc = 0;
    for (int c = 0; c < 40 && wc < 6; c++) begin
      tick();
      if (fifoc_txen) wc++;
    end
    rst = 1'b0;
    #1;
    checks += 4;
    if (wc !== 6) begin errors++; $display("[TB] FAIL midwrite_reached got %0d want 6", wc); end
    if (fifoc_txen !== 1'b0) begin errors++; $display("[TB] FAIL midwrite_txen got %b want 0", fifoc_txen); end
    if (fs !== 1'b0) begin errors++; $display("[TB] FAIL midwrite_fs got %b want 0", fs); end
    if (frm_cnt !== 8'h00) begin errors++; $display("[TB] FAIL midwrite_frmcnt got %h want 00", frm_cnt); end
    expFrm = 8'h00;
    tick();
    rst = 1'b1;
    tick();
    qGot.delete();
    qExp.delete();
    make_frame(1'b1);
    expect_frame();
    send_frame(1);
    wait_fs(60, ok);
    expFrm++;
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL postreset_fs got %b want 1", ok); end
    if (frm_cnt !== expFrm) begin errors++; $display("[TB] FAIL postreset_frmcnt got %h want %h", frm_cnt, expFrm); end
    handshake();
    fifo_diff(d);
    checks++;
    if (d !== 0) begin errors++; $display("[TB] FAIL postreset_bytes got %0d diffs want 0", d); end
  endtask

  initial begin
    rst        = 1'b0;
    rx_vld     = 1'b0;
    rx_data    = 8'h00;
    fifoc_full = 1'b0;
    fd         = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_preamble();
    test_full_stall();
    test_timeout();
    test_byte_in_sync();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
